lcd_line_writer: RTL

//  Drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.

---
 rtl/lcd_line_writer_pkg.sv | 63 ++++++
 rtl/lcd_line_writer_if.sv | 10 +
 rtl/lcd_line_writer_byte_xfer.sv | 81 ++++++++
 rtl/lcd_line_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_line_writer_pkg.sv
// Shared definitions for the HD44780 line writer: command bytes, FSM states,
// counter width and small byte helpers.
package lcd_pkg;

    // HD44780 command bytes used by the writer
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_ROW0     = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_ROW1     = 8'hC0;  // DDRAM address 0x40

    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    // Width of every timing counter; covers the ~15 ms power-up wait at 50 MHz
    localparam int CNT_W = 20;

    // Index of the last entry in the init ROM
    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        INIT  = 3'd1,
        ADDR0 = 3'd2,
        ROW0  = 3'd3,
        ADDR1 = 3'd4,
        ROW1  = 3'd5
    } lcd_state_t;

    // Init command ROM: 38,38,38,0C,06,01
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = LCD_FUNC_SET;
            3'd1:    cmd = LCD_FUNC_SET;
            3'd2:    cmd = LCD_FUNC_SET;
            3'd3:    cmd = LCD_DISP_ON;
            3'd4:    cmd = LCD_ENTRY;
            3'd5:    cmd = LCD_CLEAR;
            default: cmd = LCD_FUNC_SET;
        endcase
        return cmd;
    endfunction

    // Blank (NUL) characters become spaces so CGRAM glyph 0 is never shown
    function automatic logic [7:0] blank_to_space(input logic [7:0] ch);
        logic [7:0] res;
        if (ch == 8'h00) begin
            res = ASCII_SPACE;
        end else begin
            res = ch;
        end
        return res;
    endfunction

    // Character at column col of a 16-char line; column 0 sits in [127:120]
    function automatic logic [7:0] col_byte(input logic [127:0] line, input logic [3:0] col);
        logic [127:0] shifted;
        shifted = line << {col, 3'b000};
        return blank_to_space(shifted[127:120]);
    endfunction

endpackage

// File: rtl/lcd_line_writer_if.sv
// LCD pin bundle: the writer drives it (master), the panel/bench observes it (slave).
interface lcd_line_writer_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_e, output lcd_rs, output lcd_rw, output lcd_data);
    modport slave  (input  lcd_e, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd_line_writer_byte_xfer.sv
// One HD44780 byte write: setup, E-high strobe, then the post-write wait.
// A new start is accepted while idle or in the last wait cycle (o_done), so
// back-to-back bytes follow each other with no gap.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long_wait,
    output logic       o_done,
    output logic       o_idle,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic [7:0] o_lcd_data
);

    localparam logic [CNT_W-1:0] E_ON       = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] E_OFF      = CNT_W'(SETUP_CYC + E_HIGH_CYC);
    localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(SETUP_CYC + E_HIGH_CYC + CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(SETUP_CYC + E_HIGH_CYC + CLR_WAIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_e;
    logic             r_rs;
    logic [7:0]       r_data;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_accept  = i_start && (!r_busy || r_done);
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // Transfer counter, E strobe and held RS/DATA; E drops at once on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_last <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_e    <= 1'b0;
            r_rs   <= 1'b0;
            r_data <= 8'h00;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_last <= i_long_wait ? LAST_LONG : LAST_SHORT;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_e    <= 1'b0;
            r_rs   <= i_rs;
            r_data <= i_data;
        end else if (r_busy && !r_done) begin
            r_cnt  <= w_cnt_nxt;
            r_e    <= (w_cnt_nxt >= E_ON) && (w_cnt_nxt < E_OFF);
            r_done <= (w_cnt_nxt == r_last);
        end else begin
            // Finished with nothing queued: go idle, keep RS/DATA on the bus
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_e    <= 1'b0;
        end
    end

    assign o_done     = r_done;
    assign o_idle     = !r_busy;
    assign o_lcd_e    = r_e;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_data = r_data;

endmodule

// File: rtl/lcd_line_writer.sv
// Top level: power-up wait, HD44780 init, then endless refresh of both rows.
// Each row is snapshotted when its address command is issued so a row is
// never torn by input changes mid-write.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 82000,
    parameter int PWRUP_WAIT = 750000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [127:0]        line0_ascii,
    input  logic [127:0]        line1_ascii,
    lcd_line_writer_if.master   lcd,
    output logic                init_done,
    output logic                frame_tick
);

    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PWRUP_WAIT - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_pw_cnt;
    logic [2:0]       r_init_idx;
    logic [3:0]       r_col;
    logic [127:0]     r_snap0;
    logic [127:0]     r_snap1;
    logic             r_init_done;
    logic             r_frame_tick;

    logic             w_start;
    logic             w_rs;
    logic [7:0]       w_data;
    logic             w_long;
    logic             w_ready;
    logic             w_done;
    logic             w_idle;
    logic             w_xfer_e;
    logic             w_xfer_rs;
    logic [7:0]       w_xfer_data;

    // The byte engine can take a new byte when idle or in its final wait cycle
    assign w_ready = w_idle || w_done;
    // Only the clear command needs the long wait
    assign w_long  = (!w_rs) && (w_data == LCD_CLEAR);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the byte to issue when the engine is ready
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_data      = 8'h00;
        case (r_state)
            PWRUP: begin
                if (r_pw_cnt == PW_LAST) begin
                    w_state_nxt = INIT;
                end else begin
                    w_state_nxt = PWRUP;
                end
            end
            INIT: begin
                if (w_ready) begin
                    w_start = 1'b1;
                    w_data  = init_rom(r_init_idx);
                    if (r_init_idx == INIT_LAST) begin
                        w_state_nxt = ADDR0;
                    end else begin
                        w_state_nxt = INIT;
                    end
                end else begin
                    w_state_nxt = INIT;
                end
            end
            ADDR0: begin
                if (w_ready) begin
                    w_start     = 1'b1;
                    w_data      = LCD_ROW0;
                    w_state_nxt = ROW0;
                end else begin
                    w_state_nxt = ADDR0;
                end
            end
            ROW0: begin
                if (w_ready) begin
                    w_start = 1'b1;
                    w_rs    = 1'b1;
                    w_data  = col_byte(r_snap0, r_col);
                    if (r_col == 4'd15) begin
                        w_state_nxt = ADDR1;
                    end else begin
                        w_state_nxt = ROW0;
                    end
                end else begin
                    w_state_nxt = ROW0;
                end
            end
            ADDR1: begin
                if (w_ready) begin
                    w_start     = 1'b1;
                    w_data      = LCD_ROW1;
                    w_state_nxt = ROW1;
                end else begin
                    w_state_nxt = ADDR1;
                end
            end
            ROW1: begin
                if (w_ready) begin
                    w_start = 1'b1;
                    w_rs    = 1'b1;
                    w_data  = col_byte(r_snap1, r_col);
                    if (r_col == 4'd15) begin
                        w_state_nxt = ADDR0;
                    end else begin
                        w_state_nxt = ROW1;
                    end
                end else begin
                    w_state_nxt = ROW1;
                end
            end
            default: begin
                w_state_nxt = PWRUP;
            end
        endcase
    end

    // Power-up wait counter, init ROM index and column counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pw_cnt   <= '0;
            r_init_idx <= 3'd0;
            r_col      <= 4'd0;
        end else begin
            if (r_state == PWRUP) begin
                r_pw_cnt <= r_pw_cnt + CNT_W'(1);
            end else begin
                r_pw_cnt <= '0;
            end
            if (w_start && (r_state == INIT)) begin
                r_init_idx <= (r_init_idx == INIT_LAST) ? 3'd0 : r_init_idx + 3'd1;
            end
            // 4-bit column wraps 15 -> 0 as the row hands over to the next address
            if (w_start && ((r_state == ROW0) || (r_state == ROW1))) begin
                r_col <= r_col + 4'd1;
            end
        end
    end

    // Row snapshots, taken in the cycle the row's address command is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap0 <= '0;
            r_snap1 <= '0;
        end else begin
            if (w_start && (r_state == ADDR0)) begin
                r_snap0 <= line0_ascii;
            end
            if (w_start && (r_state == ADDR1)) begin
                r_snap1 <= line1_ascii;
            end
        end
    end

    // Status flags: ADDR0 becoming ready means the previous byte (clear or
    // row-1 column 15) has just finished its wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_done  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if ((r_state == ADDR0) && w_ready) begin
                r_init_done <= 1'b1;
            end
            r_frame_tick <= (r_state == ADDR0) && w_ready && r_init_done;
        end
    end

    lcd_byte_xfer #(
        .SETUP_CYC  (SETUP_CYC),
        .E_HIGH_CYC (E_HIGH_CYC),
        .CMD_WAIT   (CMD_WAIT),
        .CLR_WAIT   (CLR_WAIT)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_rs        (w_rs),
        .i_data      (w_data),
        .i_long_wait (w_long),
        .o_done      (w_done),
        .o_idle      (w_idle),
        .o_lcd_e     (w_xfer_e),
        .o_lcd_rs    (w_xfer_rs),
        .o_lcd_data  (w_xfer_data)
    );

    assign lcd.lcd_e    = w_xfer_e;
    assign lcd.lcd_rs   = w_xfer_rs;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_data = w_xfer_data;
    assign init_done    = r_init_done;
    assign frame_tick   = r_frame_tick;

endmodule
